envase_sequencer: RTL and testbench
===================================

// Module: envase_sequencer
// PURPOSE
//  Cycle-timed controller for the bottling line. It sequences motor, fill valve and sealer
//  from the debounced PG/CH sensors and tracks corks in the sealing tray. It runs the
//  refill request/ack handshake with the cork dispenser and raises the alarm on fill
//  timeout or cork starvation. Sits between the input debounce/toggle logic and the
//  display/dozen counters; GP feeds those counters.
// PARAMETERS
//  FILL_TIMEOUT  200  max cycles in FILL waiting for CH before FAULT (>=1)
//  SEAL_CYCLES   4    cycles VE held high per bottle (>=1)
//  TRAY_MAX      20   tray capacity in corks (<=31)
//  LOW_MARK      5    refill requested when tray_count <= LOW_MARK
//  REFILL_QTY    20   corks added per acknowledged refill
//  DISP_REFILLS  3    refills available in dispenser after reset (<=15)
// PORTS
//  clk           in   1  system clock (divided clock domain)
//  reset         in   1  asynchronous, active-high reset
//  enable        in   1  run/stop level from the on/off toggle
//  PG            in   1  bottle present
//  CH            in   1  bottle full
//  clear_fault   in   1  one-cycle pulse; leaves FAULT
//  refill_ack    in   1  dispenser has delivered REFILL_QTY corks
//  M / EV / VE   out  1  motor / fill valve / sealer
//  refill_req    out  1  request corks from dispenser (AD)
//  A             out  1  alarm
//  GP            out  1  one-cycle pulse per finished bottle
//  tray_count    out  5  corks in tray, binary
//  disp_left     out  4  refills remaining in dispenser
//  disp_empty    out  1  disp_left == 0
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: state=IDLE, M=EV=VE=A=GP=refill_req=0, tray_count=0, disp_left=DISP_REFILLS,
//   timers=0. All outputs are registered. Mid-operation reset aborts any state immediately.
//  enable=0: next cycle state=IDLE, M/EV/VE=0, refill_req dropped, counts held. FAULT is
//   kept through enable=0. In IDLE with enable=1, go to MOVE.
//  Main FSM (one transition per cycle):
//   MOVE: M=1. PG=1 -> FILL.
//   FILL: EV=1, timer counts. CH=1 -> SEAL_CHK. On the cycle timer reaches FILL_TIMEOUT
//    with CH=0 -> FAULT. CH wins if both happen on the same cycle.
//   SEAL_CHK: tray_count>0 -> SEAL; else WAIT_CORK.
//   WAIT_CORK: outputs off; A=1 while disp_empty. tray_count>0 -> SEAL.
//   SEAL: VE=1 for exactly SEAL_CYCLES cycles. On the first SEAL cycle tray_count
//    decrements by 1. After the last cycle -> DONE.
//   DONE: GP=1 for one cycle, M=1 -> MOVE. The next bottle is only accepted after PG
//    is seen 0 for >=1 cycle in MOVE (edge qualify), so one bottle is never counted twice.
//   FAULT: A=1, M/EV/VE=0. clear_fault=1 -> IDLE. Other inputs are ignored.
//  Refill handshake (independent of main FSM, active only when enable=1):
//   refill_req rises when tray_count<=LOW_MARK, !disp_empty and not in the
//    post-ack cycle. It holds high until refill_ack is sampled high.
//   On the ack cycle: disp_left-=1, tray_count=min(tray_count-consume+REFILL_QTY,
//    TRAY_MAX), where consume=1 if a seal decrement happens the same cycle.
//    refill_req=0 next cycle.
//   refill_ack while refill_req=0 is ignored. There is a min 1 idle cycle between
//    requests. disp_left never wraps below 0.
//  tray_count never underflows or exceeds TRAY_MAX. Arithmetic uses 6-bit
//   intermediates, then saturates.
// TESTING
//  T1 reset, enable=1, ack 2 cycles after req -> tray_count=20, disp_left=2,
//   req low 1 cycle after ack.
//  T2 PG=1, CH=1 after 10 cycles -> EV high 10+ cycles, VE high 4 cycles,
//   single GP pulse, tray 20->19, state back to MOVE.
//  T3 CH held 0 in FILL -> FAULT at cycle 200, A=1, EV=0; clear_fault -> IDLE, A=0.
//  T4 tray=6, seal one bottle -> tray=5 and req rises; ack on the same cycle as the
//   next seal decrement -> tray=min(5-1+20,20)=20.
//  T5 disp_left=0, tray=0, bottle filled -> WAIT_CORK, A=1, refill_req stays 0.
//  T6 enable dropped mid-SEAL -> VE=0 next cycle, IDLE; async reset mid-FILL ->
//   all outputs 0 without a clock edge.

Source files
------------

// File: rtl/envase_sequencer.sv
// Bottling-line sequencer: motor/fill/seal FSM, cork tray accounting and
// dispenser refill handshake. All outputs are registered.
module envase_sequencer #(
  parameter int FILL_TIMEOUT = 200,
  parameter int SEAL_CYCLES  = 4,
  parameter int TRAY_MAX     = 20,
  parameter int LOW_MARK     = 5,
  parameter int REFILL_QTY   = 20,
  parameter int DISP_REFILLS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       PG,
  input  logic       CH,
  input  logic       clear_fault,
  input  logic       refill_ack,
  output logic       M,
  output logic       EV,
  output logic       VE,
  output logic       refill_req,
  output logic       A,
  output logic       GP,
  output logic [4:0] tray_count,
  output logic [3:0] disp_left,
  output logic       disp_empty
);

  localparam int TW = $clog2(FILL_TIMEOUT + 1);
  localparam int SW = $clog2(SEAL_CYCLES + 1);

  localparam logic [TW-1:0] FT_LAST = TW'(FILL_TIMEOUT - 1);
  localparam logic [SW-1:0] SC_LAST = SW'(SEAL_CYCLES - 1);
  localparam logic [5:0]    QTY6    = 6'(REFILL_QTY);
  localparam logic [5:0]    MAX6    = 6'(TRAY_MAX);
  localparam logic [4:0]    MAX5    = 5'(TRAY_MAX);
  localparam logic [4:0]    LOW5    = 5'(LOW_MARK);
  localparam logic [3:0]    DISP4   = 4'(DISP_REFILLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_FILL,
    S_SEAL_CHK,
    S_WAIT_CORK,
    S_SEAL,
    S_DONE,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] fill_tmr_q, fill_tmr_d;
  logic [SW-1:0] seal_cnt_q, seal_cnt_d;
  logic          armed_q, armed_d;
  logic          post_ack_q, post_ack_d;
  logic          req_q, req_d;
  logic [4:0]    tray_q, tray_d;
  logic [3:0]    disp_q, disp_d;
  logic          m_q, ev_q, ve_q, a_q, gp_q, empty_q;
  logic          m_d, ev_d, ve_d, a_d, gp_d, empty_d;
  logic          consume;
  logic          ack_ok;
  logic [5:0]    tray_sum;

  always_comb begin
    state_d    = state_q;
    fill_tmr_d = fill_tmr_q;
    seal_cnt_d = seal_cnt_q;
    armed_d    = armed_q;
    consume    = 1'b0;
    if (!enable && state_q != S_FAULT) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_MOVE;
        S_MOVE: begin
          // a bottle is only taken after PG has been low once
          if (!PG) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = S_FILL;
            armed_d    = 1'b0;
            fill_tmr_d = '0;
          end
        end
        S_FILL: begin
          if (CH) begin
            state_d = S_SEAL_CHK;
          end else begin
            fill_tmr_d = fill_tmr_q + 1'b1;
            if (fill_tmr_q == FT_LAST) state_d = S_FAULT;
          end
        end
        S_SEAL_CHK: begin
          seal_cnt_d = '0;
          state_d    = (tray_q != 5'd0) ? S_SEAL : S_WAIT_CORK;
        end
        S_WAIT_CORK: begin
          seal_cnt_d = '0;
          if (tray_q != 5'd0) state_d = S_SEAL;
        end
        S_SEAL: begin
          if (seal_cnt_q == '0 && tray_q != 5'd0) consume = 1'b1;
          if (seal_cnt_q == SC_LAST) begin
            state_d = S_DONE;
          end else begin
            seal_cnt_d = seal_cnt_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_MOVE;
        S_FAULT: if (clear_fault) state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ack_ok     = enable && req_q && refill_ack;
    req_d      = req_q;
    post_ack_d = ack_ok;
    disp_d     = disp_q;
    if (!enable || ack_ok) begin
      req_d = 1'b0;
    end else if (!req_q && !post_ack_q &&
                 tray_q <= LOW5 && disp_q != 4'd0) begin
      req_d = 1'b1;
    end
    if (ack_ok && disp_q != 4'd0) disp_d = disp_q - 1'b1;
    tray_sum = {1'b0, tray_q} - {5'd0, consume} +
               (ack_ok ? QTY6 : 6'd0);
    tray_d   = (tray_sum > MAX6) ? MAX5 : tray_sum[4:0];
  end

  always_comb begin
    m_d     = (state_d == S_MOVE) || (state_d == S_DONE);
    ev_d    = (state_d == S_FILL);
    ve_d    = (state_d == S_SEAL);
    gp_d    = (state_d == S_DONE);
    empty_d = (disp_d == 4'd0);
    a_d     = (state_d == S_FAULT) ||
              (state_d == S_WAIT_CORK && empty_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fill_tmr_q <= '0;
      seal_cnt_q <= '0;
      armed_q    <= 1'b1;
      post_ack_q <= 1'b0;
      req_q      <= 1'b0;
      tray_q     <= 5'd0;
      disp_q     <= DISP4;
      m_q        <= 1'b0;
      ev_q       <= 1'b0;
      ve_q       <= 1'b0;
      a_q        <= 1'b0;
      gp_q       <= 1'b0;
      empty_q    <= (DISP4 == 4'd0);
    end else begin
      state_q    <= state_d;
      fill_tmr_q <= fill_tmr_d;
      seal_cnt_q <= seal_cnt_d;
      armed_q    <= armed_d;
      post_ack_q <= post_ack_d;
      req_q      <= req_d;
      tray_q     <= tray_d;
      disp_q     <= disp_d;
      m_q        <= m_d;
      ev_q       <= ev_d;
      ve_q       <= ve_d;
      a_q        <= a_d;
      gp_q       <= gp_d;
      empty_q    <= empty_d;
    end
  end

  assign M          = m_q;
  assign EV         = ev_q;
  assign VE         = ve_q;
  assign A          = a_q;
  assign GP         = gp_q;
  assign refill_req = req_q;
  assign tray_count = tray_q;
  assign disp_left  = disp_q;
  assign disp_empty = empty_q;

endmodule

// File: tb/tb_envase_sequencer.sv
// Directed bench for envase_sequencer: refill handshake, bottle cycle,
// fill timeout, refill/seal collision, cork starvation, enable and reset.
module tb_envase_sequencer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       PG;
  logic       CH;
  logic       clear_fault;
  logic       refill_ack;
  logic       M, EV, VE, refill_req, A, GP, disp_empty;
  logic [4:0] tray_count;
  logic [3:0] disp_left;

  int checks = 0;
  int errors = 0;

  envase_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .PG         (PG),
    .CH         (CH),
    .clear_fault(clear_fault),
    .refill_ack (refill_ack),
    .M          (M),
    .EV         (EV),
    .VE         (VE),
    .refill_req (refill_req),
    .A          (A),
    .GP         (GP),
    .tray_count (tray_count),
    .disp_left  (disp_left),
    .disp_empty (disp_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seal_bottle();
    PG = 1'b0; tick();
    PG = 1'b1; tick();
    CH = 1'b1; tick();
    CH = 1'b0;
    PG = 1'b0;
    repeat (6) tick();
  endtask

  task automatic wait_req();
    for (int n = 0; n < 50 && refill_req !== 1'b1; n++) tick();
    checks++;
    if (refill_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_req: refill_req=%b required 1", refill_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; PG = 1'b0; CH = 1'b0;
    clear_fault = 1'b0; refill_ack = 1'b0;
    repeat (2) tick();
    checks++;
    if ({M, EV, VE, A, GP, refill_req} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b required 000000",
               {M, EV, VE, A, GP, refill_req});
    end
    checks++;
    if (tray_count !== 5'd0 || disp_left !== 4'd3 || disp_empty !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts: tray=%0d disp=%0d empty=%b required 0 3 0",
               tray_count, disp_left, disp_empty);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_refill_handshake();
    enable = 1'b1;
    wait_req();
    checks++;
    if (M !== 1'b1) begin
      errors++;
      $display("FAIL t1_move: M=%b required 1", M);
    end
    tick(); tick();
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    checks++;
    if (tray_count !== 5'd20 || disp_left !== 4'd2) begin
      errors++;
      $display("FAIL t1_refill: tray=%0d disp=%0d required 20 2",
               tray_count, disp_left);
    end
    checks++;
    if (refill_req !== 1'b0) begin
      errors++;
      $display("FAIL t1_req_drop: refill_req=%b required 0", refill_req);
    end
    tick();
    checks++;
    if (refill_req !== 1'b0) begin
      errors++;
      $display("FAIL t1_req_idle: refill_req=%b required 0", refill_req);
    end
  endtask

  task automatic test_bottle();
    int ev_n = 0, ve_n = 0, gp_n = 0;
    PG = 1'b1;
    tick();
    if (EV === 1'b1) ev_n++;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (EV === 1'b1) ev_n++;
    end
    CH = 1'b1;
    tick();
    CH = 1'b0;
    checks++;
    if (ev_n != 10 || EV !== 1'b0) begin
      errors++;
      $display("FAIL t2_fill: ev_cycles=%0d EV=%b required 10 0", ev_n, EV);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (VE === 1'b1) ve_n++;
      if (GP === 1'b1) gp_n++;
    end
    checks++;
    if (ve_n != 4 || gp_n != 1) begin
      errors++;
      $display("FAIL t2_seal: ve_cycles=%0d gp_pulses=%0d required 4 1",
               ve_n, gp_n);
    end
    checks++;
    if (tray_count !== 5'd19) begin
      errors++;
      $display("FAIL t2_tray: tray=%0d required 19", tray_count);
    end
    checks++;
    if (M !== 1'b1 || EV !== 1'b0) begin
      errors++;
      $display("FAIL t2_move: M=%b EV=%b required 1 0", M, EV);
    end
  endtask

  task automatic test_fill_timeout();
    int ev_n = 0;
    PG = 1'b0; tick();
    PG = 1'b1; tick();
    if (EV === 1'b1) ev_n++;
    for (int i = 0; i < 300 && A !== 1'b1; i++) begin
      tick();
      if (EV === 1'b1) ev_n++;
    end
    PG = 1'b0;
    checks++;
    if (ev_n != 200 || A !== 1'b1 || EV !== 1'b0 || M !== 1'b0) begin
      errors++;
      $display("FAIL t3_timeout: ev_cycles=%0d A=%b EV=%b M=%b required 200 1 0 0",
               ev_n, A, EV, M);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (A !== 1'b1) begin
      errors++;
      $display("FAIL t3_fault_hold: A=%b required 1", A);
    end
    enable = 1'b1;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    checks++;
    if (A !== 1'b0 || M !== 1'b0) begin
      errors++;
      $display("FAIL t3_clear: A=%b M=%b required 0 0", A, M);
    end
    tick();
    checks++;
    if (M !== 1'b1) begin
      errors++;
      $display("FAIL t3_restart: M=%b required 1", M);
    end
  endtask

  task automatic test_refill_collision();
    for (int i = 0; i < 13; i++) seal_bottle();
    checks++;
    if (tray_count !== 5'd6 || refill_req !== 1'b0) begin
      errors++;
      $display("FAIL t4_tray6: tray=%0d req=%b required 6 0",
               tray_count, refill_req);
    end
    seal_bottle();
    checks++;
    if (tray_count !== 5'd5 || refill_req !== 1'b1) begin
      errors++;
      $display("FAIL t4_low: tray=%0d req=%b required 5 1",
               tray_count, refill_req);
    end
    PG = 1'b0; tick();
    PG = 1'b1; tick();
    CH = 1'b1; tick();
    CH = 1'b0; PG = 1'b0;
    tick();
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    checks++;
    if (tray_count !== 5'd20 || disp_left !== 4'd1 || refill_req !== 1'b0) begin
      errors++;
      $display("FAIL t4_collide: tray=%0d disp=%0d req=%b required 20 1 0",
               tray_count, disp_left, refill_req);
    end
    repeat (4) tick();
    checks++;
    if (tray_count !== 5'd20 || M !== 1'b1) begin
      errors++;
      $display("FAIL t4_after: tray=%0d M=%b required 20 1", tray_count, M);
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 15; i++) seal_bottle();
    wait_req();
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    checks++;
    if (tray_count !== 5'd20 || disp_left !== 4'd0 || disp_empty !== 1'b1) begin
      errors++;
      $display("FAIL t5_last_refill: tray=%0d disp=%0d empty=%b required 20 0 1",
               tray_count, disp_left, disp_empty);
    end
    for (int i = 0; i < 20; i++) seal_bottle();
    checks++;
    if (tray_count !== 5'd0 || refill_req !== 1'b0) begin
      errors++;
      $display("FAIL t5_tray_empty: tray=%0d req=%b required 0 0",
               tray_count, refill_req);
    end
    PG = 1'b0; tick();
    PG = 1'b1; tick();
    CH = 1'b1; tick();
    CH = 1'b0; PG = 1'b0;
    tick();
    checks++;
    if (A !== 1'b1 || {M, EV, VE} !== 3'b000) begin
      errors++;
      $display("FAIL t5_wait_cork: A=%b MEVVE=%b required 1 000",
               A, {M, EV, VE});
    end
    repeat (3) tick();
    checks++;
    if (A !== 1'b1 || refill_req !== 1'b0 || tray_count !== 5'd0) begin
      errors++;
      $display("FAIL t5_stuck: A=%b req=%b tray=%0d required 1 0 0",
               A, refill_req, tray_count);
    end
  endtask

  task automatic test_enable_and_async_reset();
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0;
    enable = 1'b1;
    wait_req();
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    PG = 1'b0; tick();
    PG = 1'b1; tick();
    CH = 1'b1; tick();
    CH = 1'b0; PG = 1'b0;
    tick();
    tick();
    checks++;
    if (VE !== 1'b1 || tray_count !== 5'd19) begin
      errors++;
      $display("FAIL t6_in_seal: VE=%b tray=%0d required 1 19", VE, tray_count);
    end
    enable = 1'b0;
    tick();
    checks++;
    if ({M, EV, VE, refill_req} !== 4'b0 || tray_count !== 5'd19) begin
      errors++;
      $display("FAIL t6_disable: outs=%b tray=%0d required 0000 19",
               {M, EV, VE, refill_req}, tray_count);
    end
    enable = 1'b1;
    tick();
    PG = 1'b0; tick();
    PG = 1'b1; tick();
    checks++;
    if (EV !== 1'b1) begin
      errors++;
      $display("FAIL t6_fill: EV=%b required 1", EV);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({M, EV, VE, A, GP, refill_req} !== 6'b0 || tray_count !== 5'd0 ||
        disp_left !== 4'd3) begin
      errors++;
      $display("FAIL t6_async_reset: outs=%b tray=%0d disp=%0d required 000000 0 3",
               {M, EV, VE, A, GP, refill_req}, tray_count, disp_left);
    end
    PG = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_refill_handshake();
    test_bottle();
    test_fill_timeout();
    test_refill_collision();
    test_starvation();
    test_enable_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
